// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state encoding, matrix size, key code map and column decoder.
package keypad_pkg;

    // Values double as the PresentStateFlag encoding.
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Indexed by {row, col}; entry 15 (r3,c3) is listed first.
    localparam logic [15:0][3:0] CODE_LUT = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } col_hit_t;

    // Exactly one low column is a key; none or several is no key.
    function automatic col_hit_t onehot_low(input logic [3:0] col);
        col_hit_t h;
        h.valid = 1'b1;
        h.idx   = 2'd0;
        case (col)
            4'b1110: h.idx = 2'd0;
            4'b1101: h.idx = 2'd1;
            4'b1011: h.idx = 2'd2;
            4'b0111: h.idx = 2'd3;
            default: h.valid = 1'b0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: key code link from the scanner to the system control unit.
// KeypadData/dav from master; ack from slave when KEYPAD_ACK_EN is defined.
interface keypad_if;
    import keypad_pkg::*;

    logic [3:0] KeypadData;
    logic       dav;
`ifdef KEYPAD_ACK_EN
    logic       ack;

    modport master (output KeypadData, output dav, input ack);
    modport slave  (input KeypadData, input dav, output ack);
`else
    modport master (output KeypadData, output dav);
    modport slave  (input KeypadData, input dav);
`endif

endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for the asynchronous column inputs.
// Ports: clk_i, rst_i (sync, active-high), d_i raw columns, q_o synced columns.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_COLS-1:0] d_i,
    output logic [NUM_COLS-1:0] q_o
);

    logic [NUM_COLS-1:0] s1_q;
    logic [NUM_COLS-1:0] s2_q;

    // Reset to all-high so no key is seen while leaving reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, debounces press/release, holds dav level.
// Ports: clock50MHz, reset, RowOut, ColIn, PresentStateFlag, kp (keypad_if.master).
// Optional: KEYPAD_ACK_EN adds kp.ack, which clears dav while PRESSED.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic                clock50MHz,
    input  logic                reset,
    output logic [NUM_ROWS-1:0] RowOut,
    input  logic [NUM_COLS-1:0] ColIn,
    output logic [1:0]          PresentStateFlag,
    keypad_if.master            kp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CNT - 1);

    state_e              state_q;
    logic [1:0]          row_q;
    logic [DW-1:0]       dwell_q;
    logic [CW-1:0]       cnt_q;
    logic [NUM_COLS-1:0] colpat_q;
    logic [1:0]          colidx_q;
    logic [3:0]          data_q;
    logic                dav_q;

    logic [NUM_COLS-1:0] col_s;
    col_hit_t            hit_d;
    logic [1:0]          row_inc_d;

    keypad_sync u_sync (
        .clk_i (clock50MHz),
        .rst_i (reset),
        .d_i   (ColIn),
        .q_o   (col_s)
    );

    assign hit_d     = onehot_low(col_s);
    assign row_inc_d = row_q + 2'd1;

    always_ff @(posedge clock50MHz) begin
        if (reset) begin
            state_q  <= ST_SCAN;
            row_q    <= 2'd0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            colpat_q <= '1;
            colidx_q <= 2'd0;
            data_q   <= 4'h0;
            dav_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_SCAN: begin
                    if (dwell_q == DWELL_MAX) begin
                        dwell_q <= '0;
                        if (hit_d.valid) begin
                            colpat_q <= col_s;
                            colidx_q <= hit_d.idx;
                            cnt_q    <= '0;
                            state_q  <= ST_DEBOUNCE;
                        end else begin
                            row_q <= row_inc_d;
                        end
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s == colpat_q) begin
                        if (cnt_q == CNT_MAX) begin
                            data_q  <= CODE_LUT[{row_q, colidx_q}];
                            dav_q   <= 1'b1;
                            state_q <= ST_PRESSED;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else begin
                        row_q   <= row_inc_d;
                        dwell_q <= '0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (col_s == '1) begin
                        cnt_q   <= '0;
                        state_q <= ST_RELEASE;
                    end
`ifdef KEYPAD_ACK_EN
                    if (kp.ack && dav_q) begin
                        dav_q <= 1'b0;
                    end
`endif
                end
                ST_RELEASE: begin
                    // A low column restarts the release count.
                    if (col_s == '1) begin
                        if (cnt_q == CNT_MAX) begin
                            dav_q   <= 1'b0;
                            row_q   <= 2'd0;
                            dwell_q <= '0;
                            state_q <= ST_SCAN;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    assign RowOut           = ~(4'b0001 << row_q);
    assign PresentStateFlag = state_q;
    assign kp.KeypadData    = data_q;
    assign kp.dav           = dav_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed table-driven bench for keypad_scanner.
// Uses SCAN_DIV=4, DEBOUNCE_CNT=8 and a behavioural keypad matrix model.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] RowOut;
    logic [3:0] ColIn;
    logic [1:0] st;

    logic       key_on;
    logic [3:0] krow;
    logic [3:0] kcol;

    int n_vec;
    int n_bad;

    keypad_if kp ();

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clock50MHz       (clk),
        .reset            (reset),
        .RowOut           (RowOut),
        .ColIn            (ColIn),
        .PresentStateFlag (st),
        .kp               (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key pulls its column low only while its row is driven.
    always_comb begin
        ColIn = 4'hF;
        if (key_on && (RowOut == krow)) ColIn = kcol;
    end

    typedef struct {
        int         adv;
        logic [3:0] row;
        logic [1:0] st;
        logic       dav;
        logic [3:0] data;
        logic       key_after;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input int adv, input logic [3:0] row,
                       input logic [1:0] s, input logic d,
                       input logic [3:0] data, input logic k);
        vec_t v;
        v.adv = adv; v.row = row; v.st = s;
        v.dav = d; v.data = data; v.key_after = k;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            repeat (tbl[i].adv) @(negedge clk);
            chk($sformatf("%s%0d.row", nm, i), {4'h0, RowOut}, {4'h0, tbl[i].row});
            chk($sformatf("%s%0d.st", nm, i), {6'h0, st}, {6'h0, tbl[i].st});
            chk($sformatf("%s%0d.dav", nm, i), {7'h0, kp.dav}, {7'h0, tbl[i].dav});
            chk($sformatf("%s%0d.data", nm, i), {4'h0, kp.KeypadData},
                {4'h0, tbl[i].data});
            key_on = tbl[i].key_after;
        end
        tbl.delete();
    endtask

    task automatic wait_state(input string nm, input logic [1:0] s,
                              input int lim);
        int n = 0;
        while (st !== s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {6'h0, st}, {6'h0, s});
    endtask

    task automatic wait_row(input string nm, input logic [3:0] r,
                            input int lim);
        int n = 0;
        while (RowOut !== r && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {4'h0, RowOut}, {4'h0, r});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_dav;
        logic seen_deb;
        n_vec  = 0;
        n_bad  = 0;
        key_on = 1'b0;
        krow   = 4'hF;
        kcol   = 4'hF;
        reset  = 1'b1;
`ifdef KEYPAD_ACK_EN
        kp.ack = 1'b0;
`endif

        // Reset held 3 cycles, then idle scan rotation.
        repeat (3) @(posedge clk);
        add(0, 4'hE, 2'd0, 1'b0, 4'h0, 1'b0);
        run_tbl("rst");
        reset = 1'b0;
        add(3, 4'hE, 2'd0, 1'b0, 4'h0, 1'b0);
        add(1, 4'hD, 2'd0, 1'b0, 4'h0, 1'b0);
        add(4, 4'hB, 2'd0, 1'b0, 4'h0, 1'b0);
        add(4, 4'h7, 2'd0, 1'b0, 4'h0, 1'b0);
        add(4, 4'hE, 2'd0, 1'b0, 4'h0, 1'b0);
        run_tbl("idle");

        // Clean press and release of '6' (row1, col2).
        krow = 4'hD; kcol = 4'hB; key_on = 1'b1;
        wait_row("p6_row", 4'hD, 40);
        add(3, 4'hD, 2'd0, 1'b0, 4'h0, 1'b1);
        add(1, 4'hD, 2'd1, 1'b0, 4'h0, 1'b1);
        add(7, 4'hD, 2'd1, 1'b0, 4'h0, 1'b1);
        add(1, 4'hD, 2'd2, 1'b1, 4'h6, 1'b0);
        add(2, 4'hD, 2'd2, 1'b1, 4'h6, 1'b0);
        add(1, 4'hD, 2'd3, 1'b1, 4'h6, 1'b0);
        add(7, 4'hD, 2'd3, 1'b1, 4'h6, 1'b0);
        add(1, 4'hE, 2'd0, 1'b0, 4'h6, 1'b0);
        run_tbl("p6_");

        // '#' (row3, col2) bouncing every 3 cycles, then stable.
        krow = 4'h7; kcol = 4'hB;
        wait_row("b_row", 4'h7, 40);
        seen_dav = 1'b0;
        seen_deb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_on = ((i / 3) % 2) == 0;
            if (kp.dav) seen_dav = 1'b1;
            if (st == 2'd1) seen_deb = 1'b1;
            @(negedge clk);
        end
        key_on = 1'b1;
        chk("b_nodav", {7'h0, seen_dav}, 8'h00);
        chk("b_debseen", {7'h0, seen_deb}, 8'h01);
        wait_state("b_press", 2'd2, 100);
        // Release, short re-press that restarts the release count.
        add(0, 4'h7, 2'd2, 1'b1, 4'hF, 1'b0);
        add(5, 4'h7, 2'd3, 1'b1, 4'hF, 1'b1);
        add(1, 4'h7, 2'd3, 1'b1, 4'hF, 1'b0);
        add(9, 4'h7, 2'd3, 1'b1, 4'hF, 1'b0);
        add(1, 4'hE, 2'd0, 1'b0, 4'hF, 1'b0);
        run_tbl("brel");

        // Ghost: two low columns on row 0 are never accepted.
        krow = 4'hE; kcol = 4'hC; key_on = 1'b1;
        add(3, 4'hE, 2'd0, 1'b0, 4'hF, 1'b1);
        add(1, 4'hD, 2'd0, 1'b0, 4'hF, 1'b1);
        add(4, 4'hB, 2'd0, 1'b0, 4'hF, 1'b1);
        add(4, 4'h7, 2'd0, 1'b0, 4'hF, 1'b1);
        add(4, 4'hE, 2'd0, 1'b0, 4'hF, 1'b1);
        add(4, 4'hD, 2'd0, 1'b0, 4'hF, 1'b0);
        run_tbl("ghost");

        // Reset while PRESSED, key held: re-detected and re-debounced.
        krow = 4'hD; kcol = 4'hB; key_on = 1'b1;
        wait_state("mr_press", 2'd2, 100);
        reset = 1'b1;
        add(1, 4'hE, 2'd0, 1'b0, 4'h0, 1'b1);
        run_tbl("mrst");
        reset = 1'b0;
        add(7, 4'hD, 2'd0, 1'b0, 4'h0, 1'b1);
        add(1, 4'hD, 2'd1, 1'b0, 4'h0, 1'b1);
        add(7, 4'hD, 2'd1, 1'b0, 4'h0, 1'b1);
        add(1, 4'hD, 2'd2, 1'b1, 4'h6, 1'b0);
        run_tbl("redet");
        wait_state("redet_rel", 2'd0, 60);
        chk("redet_dav", {7'h0, kp.dav}, 8'h00);

`ifdef KEYPAD_ACK_EN
        // '0' (row3, col1): ack drops dav, release still required.
        krow = 4'h7; kcol = 4'hD; key_on = 1'b1;
        wait_state("ack_press", 2'd2, 100);
        chk("ack_data", {4'h0, kp.KeypadData}, 8'h00);
        chk("ack_dav1", {7'h0, kp.dav}, 8'h01);
        kp.ack = 1'b1;
        @(negedge clk);
        kp.ack = 1'b0;
        add(0, 4'h7, 2'd2, 1'b0, 4'h0, 1'b1);
        add(20, 4'h7, 2'd2, 1'b0, 4'h0, 1'b0);
        run_tbl("ack");
        wait_state("ack_rel", 2'd0, 60);
        chk("ack_rel_dav", {7'h0, kp.dav}, 8'h00);
        key_on = 1'b1;
        wait_state("ack_again", 2'd2, 100);
        chk("ack_again_dav", {7'h0, kp.dav}, 8'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
